// File: rtl/bcd_to_bin_acc_pkg.sv
// Shared constants and state encoding for the BCD-to-binary accumulator.
// Also holds the BCD digit range check.
package bcd_to_bin_acc_pkg;

  localparam int BCD_MAX = 9;
  localparam int DIGIT_W = 4;

  typedef enum logic [0:0] {
    ST_ACC  = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  function automatic logic is_bcd(input logic [DIGIT_W-1:0] d);
    return (d <= DIGIT_W'(BCD_MAX));
  endfunction

endpackage

// File: rtl/bcd_to_bin_acc_mac10.sv
// Combinational acc*10 + digit unit, computed with guard bits and then truncated.
// The carry flag reports any truncated bits; it stays low for in-range inputs.
module bcd_to_bin_acc_mac10
  import bcd_to_bin_acc_pkg::*;
#(
  parameter int BW = 14
) (
  input  logic [BW-1:0]      acc,
  input  logic [DIGIT_W-1:0] digit,
  output logic [BW-1:0]      nxt,
  output logic               carry
);

  logic [BW+3:0] acc_w_s;
  logic [BW+3:0] wide_s;

  assign acc_w_s = {4'b0000, acc};
  // x10 as x8 + x2 keeps the datapath to shifts and adders
  assign wide_s  = (acc_w_s << 3'd3) + (acc_w_s << 3'd1) + {{BW{1'b0}}, digit};
  assign nxt     = wide_s[BW-1:0];
  assign carry   = |wide_s[BW+3:BW];

endmodule

// File: rtl/bcd_to_bin_acc.sv
// Accepts BCD digits MSD-first and accumulates them into a binary value,
// presenting value, digit count and error flag until the consumer takes it.
module bcd_to_bin_acc
  import bcd_to_bin_acc_pkg::*;
#(
  parameter int NDIG = 4,
  parameter int BW   = 14,
  parameter int CW   = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [DIGIT_W-1:0] in_digit,
  input  logic               in_last,
  output logic               in_ready,
  output logic               out_valid,
  output logic [BW-1:0]      out_bin,
  output logic [CW-1:0]      out_ndig,
  output logic               out_err,
  input  logic               out_ready
);

  state_e          state_r, state_nxt_s;
  logic [BW-1:0]   acc_r, acc_nxt_s, mac_s;
  logic [CW-1:0]   cnt_r, cnt_nxt_s;
  logic            err_r, err_nxt_s;
  logic            mac_carry_s;

  bcd_to_bin_acc_mac10 #(.BW(BW)) u_mac10 (
    .acc   (acc_r),
    .digit (in_digit),
    .nxt   (mac_s),
    .carry (mac_carry_s)
  );

  // Next-state and datapath decode; handshake outputs depend only on state_r
  always_comb begin
    state_nxt_s = state_r;
    acc_nxt_s   = acc_r;
    cnt_nxt_s   = cnt_r;
    err_nxt_s   = err_r;
    case (state_r)
      ST_ACC: begin
        if (in_valid) begin
          if (!is_bcd(in_digit)) begin
            err_nxt_s = 1'b1;
          end else if (cnt_r == CW'(NDIG)) begin
            err_nxt_s = 1'b1;
          end else begin
            acc_nxt_s = mac_s;
            cnt_nxt_s = cnt_r + CW'(1);
            err_nxt_s = err_r | mac_carry_s;
          end
          if (in_last) begin
            state_nxt_s = ST_HOLD;
          end else begin
            state_nxt_s = ST_ACC;
          end
        end else begin
          state_nxt_s = ST_ACC;
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          state_nxt_s = ST_ACC;
          acc_nxt_s   = BW'(0);
          cnt_nxt_s   = CW'(0);
          err_nxt_s   = 1'b0;
        end else begin
          state_nxt_s = ST_HOLD;
        end
      end
      default: begin
        state_nxt_s = ST_ACC;
        acc_nxt_s   = BW'(0);
        cnt_nxt_s   = CW'(0);
        err_nxt_s   = 1'b0;
      end
    endcase
  end

  // State, accumulator, digit count and sticky error registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_ACC;
      acc_r   <= BW'(0);
      cnt_r   <= CW'(0);
      err_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      acc_r   <= acc_nxt_s;
      cnt_r   <= cnt_nxt_s;
      err_r   <= err_nxt_s;
    end
  end

  assign in_ready  = (state_r == ST_ACC);
  assign out_valid = (state_r == ST_HOLD);
  assign out_bin   = acc_r;
  assign out_ndig  = cnt_r;
  assign out_err   = err_r;

endmodule

// File: tb/tb_bcd_to_bin_acc.sv
// Directed and randomized-gap bench for bcd_to_bin_acc with hand-computed
// expectations and a decimal scoreboard for the multi-number run.
module tb_bcd_to_bin_acc;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [3:0]  in_digit;
  logic        in_last;
  logic        in_ready;
  logic        out_valid;
  logic [13:0] out_bin;
  logic [2:0]  out_ndig;
  logic        out_err;
  logic        out_ready;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  bcd_to_bin_acc #(.NDIG(4), .BW(14), .CW(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_digit  (in_digit),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_bin   (out_bin),
    .out_ndig  (out_ndig),
    .out_err   (out_err),
    .out_ready (out_ready)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one digit once in_ready is seen; returns #1 after the accepting edge
  task automatic send(input logic [3:0] d, input logic last);
    int w;
    w = 0;
    while (!in_ready && w < 20) begin
      tick();
      w++;
    end
    if (!in_ready) chk("in_ready_timeout", 0, 1);
    in_valid = 1'b1;
    in_digit = d;
    in_last  = last;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic expect_result(input string tag, input int bin, input int nd, input int er);
    int w;
    w = 0;
    while (!out_valid && w < 20) begin
      tick();
      w++;
    end
    chk({tag, "_valid"}, int'(out_valid), 1);
    chk({tag, "_bin"}, int'(out_bin), bin);
    chk({tag, "_ndig"}, int'(out_ndig), nd);
    chk({tag, "_err"}, int'(out_err), er);
  endtask

  task automatic take(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_rdy_after"}, int'(in_ready), 1);
    chk({tag, "_vld_after"}, int'(out_valid), 0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_digit = 4'd0; in_last = 1'b0; out_ready = 1'b0;
    tick();
    tick();
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_bin", int'(out_bin), 0);
    chk("rst_out_ndig", int'(out_ndig), 0);
    chk("rst_out_err", int'(out_err), 0);
    rst = 1'b0;

    // 1,2,3,4: result one edge after last accept
    send(4'd1, 1'b0); send(4'd2, 1'b0); send(4'd3, 1'b0); send(4'd4, 1'b1);
    chk("t1_valid_now", int'(out_valid), 1);
    chk("t1_ready_low", int'(in_ready), 0);
    expect_result("t1", 1234, 4, 0);
    take("t1");
    chk("t1_cleared_bin", int'(out_bin), 0);

    // 0,0,7 held five cycles with ignored input traffic
    send(4'd0, 1'b0); send(4'd0, 1'b0); send(4'd7, 1'b1);
    in_valid = 1'b1; in_digit = 4'd3; in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      expect_result("t2_hold", 7, 3, 0);
      chk("t2_ready_low", int'(in_ready), 0);
      tick();
    end
    in_valid = 1'b0; in_last = 1'b0;
    take("t2");
    chk("t2_cleared_ndig", int'(out_ndig), 0);

    // Invalid digit mid-number: skipped, error sticky
    send(4'd5, 1'b0); send(4'hC, 1'b0); send(4'd9, 1'b1);
    expect_result("t3", 59, 2, 1);
    take("t3");

    // Fifth digit overflows the four-digit limit
    send(4'd9, 1'b0); send(4'd9, 1'b0); send(4'd9, 1'b0); send(4'd9, 1'b0); send(4'd8, 1'b1);
    expect_result("t4", 9999, 4, 1);
    take("t4");

    // Single invalid last digit: empty number with error
    send(4'hF, 1'b1);
    expect_result("t5", 0, 0, 1);
    take("t5");

    // Reset mid-number discards partial value; inputs ignored during reset
    send(4'd4, 1'b0); send(4'd2, 1'b0);
    rst = 1'b1; in_valid = 1'b1; in_digit = 4'd9; in_last = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    chk("t6_rst_ready", int'(in_ready), 1);
    chk("t6_rst_valid", int'(out_valid), 0);
    chk("t6_rst_ndig", int'(out_ndig), 0);
    send(4'd6, 1'b1);
    expect_result("t6", 6, 1, 0);
    take("t6");

    // Reset mid-hold drops the pending result
    send(4'd3, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t7_rst_hold_valid", int'(out_valid), 0);
    chk("t7_rst_hold_bin", int'(out_bin), 0);

    // Random gaps over 200 numbers against a decimal scoreboard
    for (int n = 0; n < 200; n++) begin
      int nd;
      int val;
      nd  = int'($urandom_range(1, 4));
      val = 0;
      for (int k = 0; k < nd; k++) begin
        logic [3:0] d;
        int gap;
        d   = 4'($urandom_range(0, 9));
        gap = int'($urandom_range(0, 2));
        for (int g = 0; g < gap; g++) begin
          out_ready = 1'($urandom_range(0, 1));
          tick();
        end
        out_ready = 1'($urandom_range(0, 1));
        val = val * 10 + int'(d);
        send(d, (k == nd - 1) ? 1'b1 : 1'b0);
      end
      out_ready = 1'b0;
      for (int g = 0; g < int'($urandom_range(0, 3)); g++) tick();
      expect_result("rnd", val, nd, 0);
      take("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bcd_to_bin_acc.md
# bcd_to_bin_acc

Sequential stage downstream of the 84-2-1-to-BCD converter. Accepts one BCD digit per handshake, most-significant digit first, and accumulates a multi-digit decimal number into binary by multiply-by-ten-and-add. On the digit flagged last it presents the binary result, digit count and error flag until the consumer takes it. Converts the converter's per-digit output into a usable binary operand.

## Interface

Parameters:
- NDIG, 4: maximum digits per number.
- BW, 14: result width; must satisfy 2^BW > 10^NDIG - 1 (14 for NDIG=4).
- CW, 3: digit-count width; must hold NDIG.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in_digit/in_last valid.
- in_digit  input  4  BCD digit from converter; legal 0..9.
- in_last  input  1  marks final digit of current number.
- in_ready  output  1  stage can accept a digit.
- out_valid  output  1  result available.
- out_bin  output  BW  accumulated binary value.
- out_ndig  output  CW  digits accepted into this number.
- out_err  output  1  invalid digit or digit overflow occurred.
- out_ready  input  1  consumer takes result.

## Operation

- States: ACC (collecting), HOLD (result presented). Reset state ACC.
- in_ready = (state == ACC); out_valid = (state == HOLD). Both derived from the state register only, with no combinational path from any input.
- Digit accept = in_valid && in_ready. On accept in ACC:
  - If in_digit > 9, set err (sticky). Accumulator and count are unchanged.
  - Else if count == NDIG, this is digit overflow: set err. Accumulator and count are unchanged.
  - Else acc <= acc*10 + in_digit and count <= count + 1. Compute acc*10 as (acc<<3)+(acc<<1) in BW+4 bits, then truncate to BW. Truncation never loses bits within the NDIG limit.
  - If in_last is high, go to HOLD regardless of the error outcome.
- HOLD: out_bin = acc, out_ndig = count, out_err = err, all stable. When out_ready is high, clear acc/count/err and return to ACC.
- in_last on an invalid or overflow digit still terminates the number.
- A number with zero valid digits (single invalid digit with in_last) yields out_bin=0, out_ndig=0, out_err=1.
- Inputs are ignored while rst is high.

## Timing

- Reset values, visible the cycle after rst is sampled high: state=ACC, acc=0, count=0, err=0. Outputs: in_ready=1, out_valid=0, out_bin=0, out_ndig=0, out_err=0.
- One digit per cycle is sustained in ACC.
- Latency: the last digit is accepted at edge N; out_valid is high from edge N (visible cycle N+1).
- HOLD→ACC transition at the edge where out_ready is sampled high. in_ready rises the following cycle; there is no same-cycle bypass.
- Back-to-back numbers therefore need at least 1 bubble cycle between them.
- rst mid-number or mid-HOLD discards all state with no output produced.
- out_ready while in ACC is ignored.

## Structure

- Shared package: constants BCD_MAX=9 and DIGIT_W=4, and a state enum {ST_ACC, ST_HOLD}.
- Natural sub-module: bcd_mac10, a combinational x10-plus-digit unit (acc, digit → next acc). Also reusable for a future binary-display path.
- Single always block for state/acc/count/err. Outputs are assigned from registers.

## Test plan

- Reset then digits 1,2,3,4 (last on 4), out_ready=1 → out_valid the cycle after the 4th accept. out_bin=1234, out_ndig=4, out_err=0. in_ready=1 one cycle after the handshake.
- Digits 0,0,7 (last) with out_ready held low 5 cycles → out_bin=7, out_ndig=3 stable all 5 cycles. in_ready=0 and further in_valid is ignored throughout.
- Digits 5, 0xC, 9 (last) → out_bin=59, out_ndig=2, out_err=1.
- NDIG=4: digits 9,9,9,9,8 (last on 8) → out_bin=9999, out_ndig=4, out_err=1.
- Digits 4,2 accepted, rst pulsed 1 cycle, then 6 (last) → out_bin=6, out_ndig=1, out_err=0.
- Random in_valid/out_ready gaps over 200 numbers of 1–4 digits, checked against a scoreboard computing the decimal value → every result matches, with no drops or duplicates.
